instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch stage that feeds the control unit. It holds a small writable program memory and a program counter. Each cycle it presents one 32-bit instruction word, together with its address, on the control unit's instruction input. It resolves the instruction's 2-bit condition field and 3-bit jump field against the flags returned by the execution unit, and it stops on a HALT opcode.

## Interface
- `ADDR_W`, default 5: program counter and memory address width. Memory depth is 2**ADDR_W words.
- `INSTR_W`, default 32: instruction word width. The field layout below is fixed for 32.

Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse; begins execution from address 0.
- `stall`  in  1  holds PC, instruction and state while high (RUN only).
- `flag`  in  4  execution-unit flags for the currently presented instruction. [0]=zero, [1]=carry, [3:2] unused here.
- `prog_we`  in  1  program memory write enable; honoured in IDLE and HALT only.
- `prog_addr`  in  ADDR_W  program memory write address.
- `prog_data`  in  INSTR_W  program memory write data.
- `instruction`  out  INSTR_W  registered instruction word to the control unit.
- `pc`  out  ADDR_W  address of `instruction`.
- `instr_valid`  out  1  `instruction` is live and must be executed this cycle.
- `halted`  out  1  high in HALT state.

## Operation
- Instruction fields:
  - opcode [31:28]
  - cond [27:26]
  - jump [25:23], signed 3-bit offset
  - load_number [22:15]
  - addr3 [14:10]
  - addr2 [9:5]
  - addr1 [4:0]
- Condition encoding:
  - 00 = never taken
  - 01 = taken if flag[0]
  - 10 = taken if flag[1]
  - 11 = always taken
- Opcode 4'hF = HALT. HALT's cond and jump fields are ignored.
- Next PC:
  - taken → pc + sign_extend(jump)
  - not taken → pc + 1
  - Arithmetic is modulo 2**ADDR_W (wraps both ways).
  - A taken jump of 0 re-executes the same word.
- Memory: combinational read at the next PC into the `instruction` register; synchronous write. Contents are not affected by reset.
- State machine:
  - IDLE → RUN on `start`: pc←0, instruction←mem[0], instr_valid←1.
  - RUN, stall=1: hold everything. instr_valid stays 1 and the instruction must not be re-issued as new.
  - RUN, stall=0, opcode≠HALT: pc←next PC, instruction←mem[next PC].
  - RUN, stall=0, opcode=HALT: → HALT; instr_valid←0, halted←1; pc and instruction hold the HALT word.
  - HALT → RUN on `start`, with the same load as IDLE→RUN.
  - `start` in RUN is ignored.
- `prog_we` in RUN is ignored (no write).
- IDLE/HALT with `prog_we` and `start` in the same cycle: the write and the start both occur. The read is before the write, so writing address 0 that cycle fetches the old mem[0].

## Timing
- Reset values: state IDLE, pc 0, instruction 0, instr_valid 0, halted 0.
- Reset asserted mid-RUN: outputs reach reset values immediately (asynchronously). Memory contents are retained.
- Start latency: instruction mem[0] is valid on the first edge after the `start` cycle.
- Throughput: one instruction per cycle when not stalled. There are no branch bubbles: the branch resolves in the same cycle the instruction is presented, using the `flag` value in that cycle.
- `stall` is sampled at each edge. A stall on a HALT word delays the HALT transition.
- `flag` is assumed combinationally valid for `instruction` within the cycle. This block adds no flag register.

## Structure
- Shared package holds:
  - field position constants (OPC_MSB/LSB, COND_*, JUMP_*, ...)
  - the condition codes COND_NEVER/COND_Z/COND_C/COND_ALWAYS
  - OPC_HALT = 4'hF
  - flag bit indices FLAG_Z=0, FLAG_C=1
  - state enum IDLE/RUN/HALT
- One sub-module, `program_memory`: 2**ADDR_W × INSTR_W, one synchronous write port, one combinational read port.
- Next-PC and condition logic stay in `instruction_fetch`.

## Test plan
- Load mem[0..3] with four cond=00 non-HALT words, then mem[4] = HALT, then pulse `start`. Expect:
  - pc sequence 0,1,2,3,4 on consecutive cycles with instr_valid=1
  - halted=1 and instr_valid=0 on the next cycle, with pc held at 4.
- mem[2] has cond=01, jump=3'b101 (−3). Expect:
  - with flag[0]=1 at pc 2: next pc = 31 (wrap)
  - with flag[0]=0: next pc = 3.
- Hold `stall` high for 3 cycles at pc 5. Expect pc=5 and `instruction` unchanged for 3 cycles, then pc 6.
- Assert `rst_n` low for 1 cycle while at pc 7 in RUN. Expect:
  - outputs go to 0 and state to IDLE immediately
  - after `start`, mem[0] is re-fetched with the previously loaded contents intact.
- In RUN, `prog_we` to address 9 with data 32'hDEADBEEF. Expect mem[9] unchanged when later fetched.
- In IDLE, `prog_we` to address 0 with `start` in the same cycle. Expect the old mem[0] fetched first, and the new value on a later start.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared field layout, condition codes, flag indices and fetch FSM states.
// Definitions only: no latency, no backpressure.
package instruction_fetch_pkg;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 28;
  localparam int COND_MSB  = 27;
  localparam int COND_LSB  = 26;
  localparam int JUMP_MSB  = 25;
  localparam int JUMP_LSB  = 23;
  localparam int LOAD_MSB  = 22;
  localparam int LOAD_LSB  = 15;
  localparam int ADDR3_MSB = 14;
  localparam int ADDR3_LSB = 10;
  localparam int ADDR2_MSB = 9;
  localparam int ADDR2_LSB = 5;
  localparam int ADDR1_MSB = 4;
  localparam int ADDR1_LSB = 0;

  localparam logic [1:0] COND_NEVER  = 2'b00;
  localparam logic [1:0] COND_Z      = 2'b01;
  localparam logic [1:0] COND_C      = 2'b10;
  localparam logic [1:0] COND_ALWAYS = 2'b11;

  localparam logic [3:0] OPC_HALT = 4'hF;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

endpackage

// File: rtl/program_memory.sv
// Program store: one synchronous write port, one combinational read port.
// Read is zero-latency; write lands on the next rising edge; no backpressure.
module program_memory #(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0]  i_raddr,
  output logic [INSTR_W-1:0] o_rdata
);

  localparam int DEPTH = 2**ADDR_W;

  logic [INSTR_W-1:0] r_mem [DEPTH];

  // Contents deliberately survive reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: presents one registered instruction per cycle, resolves cond/jump same cycle.
// Start-to-mem[0] latency one edge; i_stall freezes pc/instruction/state in RUN.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_stall,
  input  logic [3:0]         i_flag,
  input  logic               i_prog_we,
  input  logic [ADDR_W-1:0]  i_prog_addr,
  input  logic [INSTR_W-1:0] i_prog_data,
  output logic [INSTR_W-1:0] o_instruction,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_instr_valid,
  output logic               o_halted
);

  state_t             r_state;
  logic [INSTR_W-1:0] r_instruction;
  logic [ADDR_W-1:0]  r_pc;
  logic               r_instr_valid;
  logic               r_halted;

  logic [3:0]         w_opcode;
  logic [1:0]         w_cond;
  logic [2:0]         w_jump;
  logic               w_taken;
  logic [ADDR_W-1:0]  w_jump_ext;
  logic [ADDR_W-1:0]  w_next_pc;
  logic               w_load;
  logic               w_we;
  logic [ADDR_W-1:0]  w_rd_addr;
  logic [INSTR_W-1:0] w_rd_data;
  logic               w_unused;

  assign w_opcode = r_instruction[OPC_MSB:OPC_LSB];
  assign w_cond   = r_instruction[COND_MSB:COND_LSB];
  assign w_jump   = r_instruction[JUMP_MSB:JUMP_LSB];
  assign w_unused = ^{i_flag[3:2], r_instruction[LOAD_MSB:ADDR1_LSB]};

  always_comb begin
    w_taken = 1'b0;
    case (w_cond)
      COND_NEVER:  w_taken = 1'b0;
      COND_Z:      w_taken = i_flag[FLAG_Z];
      COND_C:      w_taken = i_flag[FLAG_C];
      COND_ALWAYS: w_taken = 1'b1;
      default:     w_taken = 1'b0;
    endcase
  end

  // Sign-extended offset; the adder wraps modulo 2**ADDR_W in both directions.
  assign w_jump_ext = {{(ADDR_W-3){w_jump[2]}}, w_jump};
  assign w_next_pc  = w_taken ? (r_pc + w_jump_ext) : (r_pc + ADDR_W'(1));

  assign w_load    = (r_state != RUN) && i_start;
  assign w_we      = i_prog_we && (r_state != RUN);
  assign w_rd_addr = w_load ? '0 : w_next_pc;

  program_memory #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_program_memory (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (i_prog_addr),
    .i_wdata (i_prog_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pc          <= '0;
      r_instruction <= '0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, HALT: begin
          if (i_start) begin
            r_state       <= RUN;
            r_pc          <= '0;
            r_instruction <= w_rd_data;
            r_instr_valid <= 1'b1;
            r_halted      <= 1'b0;
          end
        end
        RUN: begin
          if (!i_stall) begin
            if (w_opcode == OPC_HALT) begin
              r_state       <= HALT;
              r_instr_valid <= 1'b0;
              r_halted      <= 1'b1;
            end else begin
              r_pc          <= w_next_pc;
              r_instruction <= w_rd_data;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_instruction = r_instruction;
  assign o_pc          = r_pc;
  assign o_instr_valid = r_instr_valid;
  assign o_halted      = r_halted;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: vector table, directed corner sequences, random run vs reference model.
// Outputs are compared 1 time unit after each rising edge.
module tb_instruction_fetch;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [3:0]  flag = 4'h0;
  logic        prog_we = 1'b0;
  logic [4:0]  prog_addr = 5'd0;
  logic [31:0] prog_data = 32'h0;
  logic [31:0] instruction;
  logic [4:0]  pc;
  logic        instr_valid;
  logic        halted;

  int n_pass = 0;
  int n_tot  = 0;

  instruction_fetch #(.ADDR_W(ADDR_W), .INSTR_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (start),
    .i_stall       (stall),
    .i_flag        (flag),
    .i_prog_we     (prog_we),
    .i_prog_addr   (prog_addr),
    .i_prog_data   (prog_data),
    .o_instruction (instruction),
    .o_pc          (pc),
    .o_instr_valid (instr_valid),
    .o_halted      (halted)
  );

  always #5 clk = ~clk;

  // Reference model: architectural view (running/halted, pc as integer, memory array).
  logic [31:0] m_mem [DEPTH];
  int          m_pc;
  logic [31:0] m_instr;
  bit          m_run, m_valid, m_halted;

  function automatic logic [31:0] mk(logic [3:0] op, logic [1:0] c, logic [2:0] j, logic [22:0] rest);
    return {op, c, j, rest};
  endfunction

  function automatic logic [31:0] fillw(int i);
    return mk(4'h2, 2'b00, 3'b011, 23'h0ABC00 + 23'(i));
  endfunction

  function automatic void model_reset();
    m_pc = 0; m_instr = 32'h0; m_run = 0; m_valid = 0; m_halted = 0;
  endfunction

  function automatic void model_edge();
    int  j;
    bit  tk;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_run) begin
      if (!stall) begin
        if (m_instr[31:28] == 4'hF) begin
          m_run = 0; m_valid = 0; m_halted = 1;
        end else begin
          j = int'(m_instr[25:23]);
          if (j > 3) j = j - 8;
          case (m_instr[27:26])
            2'b00:   tk = 1'b0;
            2'b01:   tk = flag[0];
            2'b10:   tk = flag[1];
            default: tk = 1'b1;
          endcase
          m_pc    = tk ? (((m_pc + j) % DEPTH) + DEPTH) % DEPTH : (m_pc + 1) % DEPTH;
          m_instr = m_mem[m_pc];
        end
      end
    end else begin
      if (start) begin
        m_instr = m_mem[0]; m_pc = 0; m_run = 1; m_valid = 1; m_halted = 0;
      end
      if (prog_we) m_mem[prog_addr] = prog_data;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic cmp_model();
    chk("model_pc", 32'(pc), 32'(m_pc));
    chk("model_instr", instruction, m_instr);
    chk("model_valid", 32'(instr_valid), 32'(m_valid));
    chk("model_halted", 32'(halted), 32'(m_halted));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    cmp_model();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    cyc();
    prog_we = 1'b0;
  endtask

  task automatic chk_out(input string nm, input logic [4:0] e_pc, input logic [31:0] e_ins,
                         input logic e_v, input logic e_h);
    chk({nm, "_pc"}, 32'(pc), 32'(e_pc));
    chk({nm, "_instr"}, instruction, e_ins);
    chk({nm, "_valid"}, 32'(instr_valid), 32'(e_v));
    chk({nm, "_halted"}, 32'(halted), 32'(e_h));
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 5'd0, 32'h0, 1'b0, 1'b0);
    model_reset();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic run_to_halt(input string nm);
    for (int k = 0; k < 40 && !halted; k++) cyc();
    chk(nm, 32'(halted), 32'd1);
  endtask

  typedef struct {
    logic        start, stall, we;
    logic [3:0]  flag;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [4:0]  e_pc;
    logic [31:0] e_instr;
    logic        e_valid, e_halted;
  } vec_t;

  vec_t        tbl [12];
  logic [31:0] w [4];
  logic [31:0] haltw, jw, neww, rw;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    model_reset();
    for (int i = 0; i < 4; i++) w[i] = mk(4'h1 + 4'(i), 2'b00, 3'b111, 23'h001000 + 23'(i));
    haltw = mk(4'hF, 2'b11, 3'b010, 23'h000005);
    jw    = mk(4'h3, 2'b01, 3'b101, 23'h000022);
    neww  = mk(4'h4, 2'b00, 3'b000, 23'h7FFFFF);

    // Straight-line program ending in HALT; never-taken words ignore all-ones flags.
    for (int i = 0; i < 12; i++)
      tbl[i] = '{start:1'b0, stall:1'b0, we:1'b0, flag:4'hF, addr:5'd0, data:32'h0,
                 e_pc:5'd0, e_instr:32'h0, e_valid:1'b0, e_halted:1'b0};
    for (int i = 0; i < 5; i++) begin
      tbl[i].we   = 1'b1;
      tbl[i].addr = 5'(i);
      tbl[i].data = (i == 4) ? haltw : w[i];
    end
    tbl[5].start = 1'b1;
    for (int i = 5; i < 9; i++) begin
      tbl[i].e_pc = 5'(i - 5); tbl[i].e_instr = w[i-5]; tbl[i].e_valid = 1'b1;
    end
    tbl[9].e_pc = 5'd4; tbl[9].e_instr = haltw; tbl[9].e_valid = 1'b1;
    for (int i = 10; i < 12; i++) begin
      tbl[i].e_pc = 5'd4; tbl[i].e_instr = haltw; tbl[i].e_halted = 1'b1;
    end

    #1 rst_n = 1'b0;
    #2;
    chk_out("reset", 5'd0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_out("reset_edge", 5'd0, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < DEPTH; i++) wr(5'(i), fillw(i));

    for (int i = 0; i < 12; i++) begin
      start = tbl[i].start; stall = tbl[i].stall; flag = tbl[i].flag;
      prog_we = tbl[i].we; prog_addr = tbl[i].addr; prog_data = tbl[i].data;
      cyc();
      chk_out($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_instr, tbl[i].e_valid, tbl[i].e_halted);
    end
    start = 1'b0; prog_we = 1'b0; flag = 4'h0;

    // Writes accepted in HALT.
    wr(5'd2, jw); wr(5'd31, haltw); wr(5'd4, fillw(4)); wr(5'd10, haltw);

    start = 1'b1; cyc(); start = 1'b0;
    chk("restart_pc0", 32'(pc), 32'd0);
    cyc(); cyc();
    chk("jump_word", instruction, jw);
    flag = 4'b0001; cyc(); flag = 4'h0;
    chk("jump_wrap_pc", 32'(pc), 32'd31);
    cyc();
    chk_out("halt_at31", 5'd31, haltw, 1'b0, 1'b1);

    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    flag = 4'b0010; cyc(); flag = 4'h0;
    chk("jump_not_taken_pc", 32'(pc), 32'd3);
    cyc(); cyc();
    chk("pre_stall_pc", 32'(pc), 32'd5);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start = (k == 1);
      cyc();
      chk_out($sformatf("stall%0d", k), 5'd5, fillw(5), 1'b1, 1'b0);
    end
    stall = 1'b0; start = 1'b0;
    cyc();
    chk("post_stall_pc", 32'(pc), 32'd6);
    cyc();
    chk("pc7", 32'(pc), 32'd7);
    async_reset();

    start = 1'b1; cyc(); start = 1'b0;
    chk_out("mem_retained", 5'd0, w[0], 1'b1, 1'b0);
    wr(5'd9, 32'hDEADBEEF);
    for (int k = 0; k < 20 && pc !== 5'd9; k++) cyc();
    chk_out("run_write_ignored", 5'd9, fillw(9), 1'b1, 1'b0);
    run_to_halt("halt_at10");
    chk("halt_pc10", 32'(pc), 32'd10);

    async_reset();
    start = 1'b1; prog_we = 1'b1; prog_addr = 5'd0; prog_data = neww;
    cyc();
    start = 1'b0; prog_we = 1'b0;
    chk("idle_wr_start_old", instruction, w[0]);
    run_to_halt("halt_again");
    start = 1'b1; cyc(); start = 1'b0;
    chk("new_mem0", instruction, neww);

    // Random phase against the reference model.
    async_reset();
    for (int i = 0; i < DEPTH; i++) begin
      rw = $urandom;
      if ($urandom_range(0, 7) == 0) rw[31:28] = 4'hF;
      wr(5'(i), rw);
    end
    for (int n = 0; n < 3000; n++) begin
      start   = ($urandom_range(0, 9) == 0);
      stall   = ($urandom_range(0, 3) == 0);
      flag    = 4'($urandom);
      prog_we = ($urandom_range(0, 5) == 0);
      prog_addr = 5'($urandom);
      rw = $urandom;
      if ($urandom_range(0, 7) == 0) rw[31:28] = 4'hF;
      prog_data = rw;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
